// File: rtl/vram_loader.sv
// VRAM loader: turns a screen-dump byte stream into single-cycle VRAM writes that yield to the
// CPU, then latches the trailing scroll and border/mode bytes.
module vram_loader #(
    parameter logic [15:0] BASE_ADDR  = 16'h8000,
    parameter int unsigned VRAM_BYTES = 32768,
    parameter int unsigned GAP        = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        cpu_we,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic [7:0]  scroll,
    output logic [3:0]  border,
    output logic        mode512,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [15:0] LAST_IDX = 16'(VRAM_BYTES - 1);
    localparam logic [3:0]  GAP_LOAD = 4'(GAP);

    logic [1:0]  state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        tail_idx_q, tail_idx_d;
    logic        pending_q, pending_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  scroll_q, scroll_d;
    logic [3:0]  border_q, border_d;
    logic        mode512_q, mode512_d;

    logic abort_now;
    logic accept;

    assign abort_now = abort && (state_q != ST_IDLE);

    // Only the final VRAM write gates the tail bytes; the gap and CPU traffic do not.
    always_comb begin
        in_ready = 1'b0;
        if (state_q == ST_DATA) begin
            in_ready = ~pending_q & ~cpu_we & (gap_q == 4'd0);
        end else if (state_q == ST_TAIL) begin
            in_ready = ~pending_q;
        end
        if (abort_now) begin
            in_ready = 1'b0;
        end
    end

    assign accept  = in_valid & in_ready;
    assign we      = pending_q & ~cpu_we & ~abort_now;
    assign busy    = (state_q == ST_DATA) || (state_q == ST_TAIL);
    assign done    = (state_q == ST_DONE) && !abort_now;
    assign addr    = addr_q;
    assign dout    = dout_q;
    assign scroll  = scroll_q;
    assign border  = border_q;
    assign mode512 = mode512_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tail_idx_d = tail_idx_q;
        pending_d  = pending_q;
        gap_d      = gap_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        scroll_d   = scroll_q;
        border_d   = border_q;
        mode512_d  = mode512_q;

        if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
        if (we) begin
            pending_d = 1'b0;
            gap_d     = GAP_LOAD;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DATA;
                    count_d    = 16'd0;
                    tail_idx_d = 1'b0;
                    pending_d  = 1'b0;
                    gap_d      = 4'd0;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    addr_d    = BASE_ADDR + count_q;
                    dout_d    = in_data;
                    pending_d = 1'b1;
                    count_d   = count_q + 16'd1;
                    if (count_q == LAST_IDX) begin
                        state_d    = ST_TAIL;
                        tail_idx_d = 1'b0;
                    end
                end
            end
            ST_TAIL: begin
                if (accept) begin
                    if (!tail_idx_q) begin
                        scroll_d   = in_data;
                        tail_idx_d = 1'b1;
                    end else begin
                        border_d  = in_data[3:0];
                        mode512_d = in_data[4];
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pending write is dropped; latched display settings are kept.
        if (abort_now) begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
            gap_d     = 4'd0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= 16'd0;
            tail_idx_q <= 1'b0;
            pending_q  <= 1'b0;
            gap_q      <= 4'd0;
            addr_q     <= 16'd0;
            dout_q     <= 8'd0;
            scroll_q   <= 8'hFF;
            border_q   <= 4'd0;
            mode512_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tail_idx_q <= tail_idx_d;
            pending_q  <= pending_d;
            gap_q      <= gap_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            scroll_q   <= scroll_d;
            border_q   <= border_d;
            mode512_q  <= mode512_d;
        end
    end

endmodule

// File: tb/tb_vram_loader.sv
// Bench for vram_loader: two instances (GAP=0 at 8000, GAP=3 wrapping at FFFE) checked against
// a stream-level model of expected writes and latched tail values.
module tb_vram_loader;

    localparam logic [15:0] BASE_A = 16'h8000;
    localparam int          N_A    = 4;
    localparam int          GAP_A  = 0;
    localparam logic [15:0] BASE_B = 16'hFFFE;
    localparam int          N_B    = 5;
    localparam int          GAP_B  = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        start, abort, in_valid, cpu_we;
    logic [7:0]  in_data;
    logic        sel;
    logic        start_a, start_b, abort_a, abort_b;

    logic        in_ready_a, we_a, mode512_a, busy_a, done_a;
    logic [15:0] addr_a;
    logic [7:0]  dout_a, scroll_a;
    logic [3:0]  border_a;
    logic        in_ready_b, we_b, mode512_b, busy_b, done_b;
    logic [15:0] addr_b;
    logic [7:0]  dout_b, scroll_b;
    logic [3:0]  border_b;

    logic        in_ready_s, we_s, mode512_s, busy_s, done_s;
    logic [15:0] addr_s;
    logic [7:0]  dout_s, scroll_s;
    logic [3:0]  border_s;

    // Only the selected instance ever sees start/abort, so the other stays idle.
    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign abort_a = abort & ~sel;
    assign abort_b = abort & sel;

    vram_loader #(.BASE_ADDR(BASE_A), .VRAM_BYTES(N_A), .GAP(GAP_A)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a), .cpu_we(cpu_we),
        .addr(addr_a), .dout(dout_a), .we(we_a), .scroll(scroll_a), .border(border_a),
        .mode512(mode512_a), .busy(busy_a), .done(done_a)
    );

    vram_loader #(.BASE_ADDR(BASE_B), .VRAM_BYTES(N_B), .GAP(GAP_B)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b), .cpu_we(cpu_we),
        .addr(addr_b), .dout(dout_b), .we(we_b), .scroll(scroll_b), .border(border_b),
        .mode512(mode512_b), .busy(busy_b), .done(done_b)
    );

    always_comb begin
        in_ready_s = sel ? in_ready_b : in_ready_a;
        we_s       = sel ? we_b       : we_a;
        addr_s     = sel ? addr_b     : addr_a;
        dout_s     = sel ? dout_b     : dout_a;
        scroll_s   = sel ? scroll_b   : scroll_a;
        border_s   = sel ? border_b   : border_a;
        mode512_s  = sel ? mode512_b  : mode512_a;
        busy_s     = sel ? busy_b     : busy_a;
        done_s     = sel ? done_b     : done_a;
    end

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovl = 0;
    int done_cnt = 0;

    logic [15:0] we_addr_q[$];
    logic [7:0]  we_data_q[$];
    int          we_cyc_q[$];
    int          acc_q[$];
    logic [7:0]  stim_q[$];

    logic [7:0]  m_scroll[2];
    logic [3:0]  m_border[2];
    logic        m_mode[2];

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (we_s === 1'b1) begin
            we_addr_q.push_back(addr_s);
            we_data_q.push_back(dout_s);
            we_cyc_q.push_back(cyc);
        end
        if (we_s && cpu_we) ovl++;
        if (done_s) done_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        we_cyc_q.delete();
        acc_q.delete();
        ovl = 0;
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b1; cpu_we = 1'b0; in_data = 8'hA5;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_scroll[d] = 8'hFF;
            m_border[d] = 4'd0;
            m_mode[d]   = 1'b0;
        end
    endtask

    task automatic make_stim(input int n);
        stim_q.delete();
        for (int i = 0; i < n + 2; i++) stim_q.push_back(8'($urandom));
    endtask

    // Reference model: a completed load latches the two bytes following the VRAM image.
    task automatic model_commit(input int n);
        m_scroll[sel] = stim_q[n];
        m_border[sel] = stim_q[n + 1][3:0];
        m_mode[sel]   = stim_q[n + 1][4];
    endtask

    task automatic run_load(input int valid_pct, input int cpu_pct, input int stall_first,
                            input int abort_at, input bit start_noise);
        int idx = 0;
        int stall = 0;
        int budget = 0;
        bit aborted = 1'b0;
        clear_mon();
        @(posedge clk_sys);
        #1 start = 1'b1;
        while (idx < stim_q.size() && !aborted && budget < 2000) begin
            @(posedge clk_sys);
            #1;
            budget++;
            start = start_noise ? ($urandom_range(99) < 20) : 1'b0;
            if (abort_at >= 0 && idx == abort_at) begin
                abort = 1'b1; in_valid = 1'b1; cpu_we = 1'b0; aborted = 1'b1;
            end else begin
                if (stall > 0) begin
                    cpu_we = 1'b1;
                    stall--;
                end else begin
                    cpu_we = ($urandom_range(99) < 32'(cpu_pct));
                end
                in_valid = ($urandom_range(99) < 32'(valid_pct));
            end
            in_data = stim_q[idx];
            @(negedge clk_sys);
            if (!aborted && in_valid && in_ready_s) begin
                acc_q.push_back(cyc);
                if (idx == 0) stall = stall_first;
                idx++;
            end
        end
        @(posedge clk_sys);
        #1 start = 1'b0; abort = 1'b0; in_valid = 1'b0; cpu_we = 1'b0;
        checks++;
        if (idx != (aborted ? abort_at : stim_q.size())) begin
            errors++;
            $display("FAIL load_progress: accepted %0d bytes, want %0d", idx,
                     aborted ? abort_at : stim_q.size());
        end
        repeat (8) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        @(negedge clk_sys);
        checks++; if (scroll_s !== 8'hFF) begin errors++; $display("FAIL reset_scroll: got %h want FF", scroll_s); end
        checks++; if (border_s !== 4'd0) begin errors++; $display("FAIL reset_border: got %h want 0", border_s); end
        checks++; if (mode512_s !== 1'b0) begin errors++; $display("FAIL reset_mode512: got %b want 0", mode512_s); end
        checks++; if (we_s !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_s); end
        checks++; if (in_ready_s !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_s); end
        checks++; if (addr_s !== 16'd0 || dout_s !== 8'd0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0000/00", addr_s, dout_s); end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        sel = 1'b0;
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h13};
        run_load(100, 0, 0, -1, 1'b0);
        model_commit(N_A);
        checks++; if (we_addr_q.size() != N_A) begin errors++; $display("FAIL basic_write_count: got %0d want %0d", we_addr_q.size(), N_A); end
        for (int i = 0; i < we_addr_q.size() && i < N_A; i++) begin
            checks++;
            if (we_addr_q[i] !== BASE_A + 16'(i) || we_data_q[i] !== stim_q[i]) begin
                errors++;
                $display("FAIL basic_write[%0d]: got %h/%h want %h/%h", i, we_addr_q[i], we_data_q[i], BASE_A + 16'(i), stim_q[i]);
            end
            checks++; if (we_cyc_q[i] != acc_q[i] + 1) begin errors++; $display("FAIL basic_latency[%0d]: got %0d want 1", i, we_cyc_q[i] - acc_q[i]); end
        end
        for (int i = 1; i <= N_A && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] - acc_q[i - 1] != 2) begin errors++; $display("FAIL basic_rate[%0d]: got %0d want 2", i, acc_q[i] - acc_q[i - 1]); end
        end
        checks++; if (scroll_s !== 8'h05) begin errors++; $display("FAIL basic_scroll: got %h want 05", scroll_s); end
        checks++; if (border_s !== 4'h3) begin errors++; $display("FAIL basic_border: got %h want 3", border_s); end
        checks++; if (mode512_s !== 1'b1) begin errors++; $display("FAIL basic_mode512: got %b want 1", mode512_s); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy_s); end
    endtask

    task automatic test_abort();
        sel = 1'b0;
        make_stim(N_A);
        run_load(100, 0, 0, 3, 1'b0);
        checks++; if (we_addr_q.size() != 2) begin errors++; $display("FAIL abort_write_count: got %0d want 2", we_addr_q.size()); end
        for (int i = 0; i < we_addr_q.size() && i < 2; i++) begin
            checks++;
            if (we_addr_q[i] !== BASE_A + 16'(i) || we_data_q[i] !== stim_q[i]) begin
                errors++;
                $display("FAIL abort_write[%0d]: got %h/%h want %h/%h", i, we_addr_q[i], we_data_q[i], BASE_A + 16'(i), stim_q[i]);
            end
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_s); end
        checks++; if (scroll_s !== m_scroll[0] || border_s !== m_border[0] || mode512_s !== m_mode[0]) begin
            errors++;
            $display("FAIL abort_settings: got %h/%h/%b want %h/%h/%b", scroll_s, border_s, mode512_s, m_scroll[0], m_border[0], m_mode[0]);
        end
    endtask

    task automatic test_ignore();
        int bad = 0;
        sel = 1'b0;
        clear_mon();
        repeat (6) begin
            @(posedge clk_sys);
            #1 in_valid = 1'b1; in_data = 8'($urandom);
            @(negedge clk_sys);
            if (in_ready_s) bad++;
        end
        @(posedge clk_sys);
        #1 in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_in_ready: got %0d ready cycles want 0", bad); end
        checks++; if (we_addr_q.size() != 0) begin errors++; $display("FAIL idle_we: got %0d writes want 0", we_addr_q.size()); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy_s); end
        make_stim(N_A);
        run_load(80, 20, 0, -1, 1'b1);
        model_commit(N_A);
        checks++; if (we_addr_q.size() != N_A) begin errors++; $display("FAIL restart_write_count: got %0d want %0d", we_addr_q.size(), N_A); end
        for (int i = 0; i < we_addr_q.size() && i < N_A; i++) begin
            checks++;
            if (we_addr_q[i] !== BASE_A + 16'(i) || we_data_q[i] !== stim_q[i]) begin
                errors++;
                $display("FAIL restart_write[%0d]: got %h/%h want %h/%h", i, we_addr_q[i], we_data_q[i], BASE_A + 16'(i), stim_q[i]);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d pulses want 1", done_cnt); end
        checks++; if (ovl != 0) begin errors++; $display("FAIL restart_overlap: got %0d want 0", ovl); end
    endtask

    task automatic test_cpu_stall();
        sel = 1'b0;
        do_reset();
        in_valid = 1'b0;
        make_stim(N_A);
        run_load(100, 0, 3, -1, 1'b0);
        model_commit(N_A);
        checks++; if (we_addr_q.size() != N_A) begin errors++; $display("FAIL stall_write_count: got %0d want %0d", we_addr_q.size(), N_A); end
        if (we_cyc_q.size() > 0 && acc_q.size() > 0) begin
            checks++; if (we_cyc_q[0] - acc_q[0] != 4) begin errors++; $display("FAIL stall_latency: got %0d want 4", we_cyc_q[0] - acc_q[0]); end
        end
        for (int i = 0; i < we_addr_q.size() && i < N_A; i++) begin
            checks++;
            if (we_addr_q[i] !== BASE_A + 16'(i) || we_data_q[i] !== stim_q[i]) begin
                errors++;
                $display("FAIL stall_write[%0d]: got %h/%h want %h/%h", i, we_addr_q[i], we_data_q[i], BASE_A + 16'(i), stim_q[i]);
            end
        end
        checks++; if (ovl != 0) begin errors++; $display("FAIL stall_overlap: got %0d want 0", ovl); end
        checks++; if (scroll_s !== m_scroll[0]) begin errors++; $display("FAIL stall_scroll: got %h want %h", scroll_s, m_scroll[0]); end
    endtask

    task automatic test_gap();
        sel = 1'b1;
        make_stim(N_B);
        run_load(100, 0, 0, -1, 1'b0);
        model_commit(N_B);
        checks++; if (we_addr_q.size() != N_B) begin errors++; $display("FAIL gap_write_count: got %0d want %0d", we_addr_q.size(), N_B); end
        for (int i = 0; i < we_addr_q.size() && i < N_B; i++) begin
            checks++;
            if (we_addr_q[i] !== BASE_B + 16'(i) || we_data_q[i] !== stim_q[i]) begin
                errors++;
                $display("FAIL gap_write[%0d]: got %h/%h want %h/%h", i, we_addr_q[i], we_data_q[i], BASE_B + 16'(i), stim_q[i]);
            end
            if (i > 0) begin
                checks++; if (we_cyc_q[i] - we_cyc_q[i - 1] != 5) begin errors++; $display("FAIL gap_spacing[%0d]: got %0d want 5", i, we_cyc_q[i] - we_cyc_q[i - 1]); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL gap_done: got %0d pulses want 1", done_cnt); end
        checks++; if (scroll_s !== m_scroll[1] || border_s !== m_border[1] || mode512_s !== m_mode[1]) begin
            errors++;
            $display("FAIL gap_settings: got %h/%h/%b want %h/%h/%b", scroll_s, border_s, mode512_s, m_scroll[1], m_border[1], m_mode[1]);
        end
    endtask

    task automatic test_random();
        int n;
        int gap;
        logic [15:0] base;
        for (int it = 0; it < 16; it++) begin
            sel  = 1'($urandom_range(1));
            n    = sel ? N_B : N_A;
            gap  = sel ? GAP_B : GAP_A;
            base = sel ? BASE_B : BASE_A;
            make_stim(n);
            run_load(int'($urandom_range(100, 40)), int'($urandom_range(50)), 0, -1, 1'b1);
            model_commit(n);
            checks++; if (we_addr_q.size() != n) begin errors++; $display("FAIL rand_write_count[%0d]: got %0d want %0d", it, we_addr_q.size(), n); end
            for (int i = 0; i < we_addr_q.size() && i < n; i++) begin
                checks++;
                if (we_addr_q[i] !== base + 16'(i) || we_data_q[i] !== stim_q[i]) begin
                    errors++;
                    $display("FAIL rand_write[%0d.%0d]: got %h/%h want %h/%h", it, i, we_addr_q[i], we_data_q[i], base + 16'(i), stim_q[i]);
                end
                checks++; if (we_cyc_q[i] <= acc_q[i]) begin errors++; $display("FAIL rand_latency[%0d.%0d]: got %0d want >=1", it, i, we_cyc_q[i] - acc_q[i]); end
                if (i > 0) begin
                    checks++; if (we_cyc_q[i] - we_cyc_q[i - 1] < gap + 2) begin errors++; $display("FAIL rand_spacing[%0d.%0d]: got %0d want >=%0d", it, i, we_cyc_q[i] - we_cyc_q[i - 1], gap + 2); end
                end
            end
            checks++; if (ovl != 0) begin errors++; $display("FAIL rand_overlap[%0d]: got %0d want 0", it, ovl); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done[%0d]: got %0d pulses want 1", it, done_cnt); end
            checks++; if (scroll_s !== m_scroll[sel] || border_s !== m_border[sel] || mode512_s !== m_mode[sel]) begin
                errors++;
                $display("FAIL rand_settings[%0d]: got %h/%h/%b want %h/%h/%b", it, scroll_s, border_s, mode512_s, m_scroll[sel], m_border[sel], m_mode[sel]);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_basic();
        test_abort();
        test_ignore();
        test_cpu_stall();
        test_gap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
